// File: rtl/bist_chain_ctrl_pkg.sv
// Shared encodings and helpers for the BIST chain sequencer.
package bist_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_RESET   = 2'b00,
    OP_CAPTURE = 2'b01,
    OP_SHIFT   = 2'b10,
    OP_UPDATE  = 2'b11
  } op_e;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t RST   = 3'd1;
  localparam state_t SETUP = 3'd2;
  localparam state_t PULSE = 3'd3;
  localparam state_t HOLD  = 3'd4;
  localparam state_t DONE  = 3'd5;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bist_chain_ctrl_if.sv
// Host command/response bus of the BIST chain sequencer.
interface bist_chain_ctrl_if #(
  parameter int CHAIN_LEN = 8
) ();

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [CHAIN_LEN-1:0] cmd_data;
  logic                 rsp_valid;
  logic [CHAIN_LEN-1:0] rsp_data;
  logic                 busy;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_data,
    input  busy
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready,
    output rsp_valid,
    output rsp_data,
    output busy
  );

endinterface

// File: rtl/bist_chain_ctrl_bit_counter.sv
// Loadable down-counter with terminal-count flag; times the shift loop and the reset hold.
module bist_bit_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign tc = (count_reg == '0);

endmodule

// File: rtl/bist_chain_ctrl.sv
// Sequencer driving one chain of BIST register cells: reset, capture, shift and update commands.
module bist_chain_ctrl
  import bist_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN  = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  bist_chain_ctrl_if.slave host,
  output logic             Shift_DR,
  output logic             BIST_Sh_t_clk,
  output logic             BIST_Com_t_clk,
  output logic             Test_Log_Res,
  output logic             chain_si,
  input  logic             chain_so
);

  localparam int CNT_MAX = (CHAIN_LEN > RST_CYCLES) ? CHAIN_LEN : RST_CYCLES;
  localparam int CNT_W   = cnt_width(CNT_MAX);

  state_t               state_reg, state_next;
  op_e                  op_reg;
  logic [CHAIN_LEN-1:0] tx_reg;
  logic [CHAIN_LEN-1:0] rx_reg;
  logic [CHAIN_LEN-1:0] rsp_data_reg;
  logic                 cmd_ready_reg;
  logic                 busy_reg;
  logic                 rsp_valid_reg;
  logic                 shift_dr_reg;
  logic                 sh_t_reg;
  logic                 com_t_reg;
  logic                 tlr_reg;
  logic                 chain_si_reg;

  logic                 accept;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic [CNT_W-1:0]     cnt_load_val;
  logic                 cnt_tc;
  logic                 in_bit_window;

  assign accept = host.cmd_valid && cmd_ready_reg;

  bist_bit_counter #(
    .WIDTH (CNT_W)
  ) u_bit_cnt (
    .clk      (clk),
    .srst     (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_next   = state_reg;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = '0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          cnt_load = 1'b1;
          if (op_e'(host.cmd_op) == OP_RESET) begin
            state_next   = RST;
            cnt_load_val = CNT_W'(RST_CYCLES - 1);
          end else begin
            state_next   = SETUP;
            cnt_load_val = CNT_W'(CHAIN_LEN - 1);
          end
        end
      end
      RST: begin
        if (cnt_tc) state_next = DONE;
        else        cnt_dec    = 1'b1;
      end
      SETUP: state_next = PULSE;
      PULSE: state_next = HOLD;
      HOLD: begin
        // Only SHIFT loops; CAPTURE/UPDATE are a single strobe.
        if ((op_reg == OP_SHIFT) && !cnt_tc) begin
          cnt_dec    = 1'b1;
          state_next = SETUP;
        end else begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_bit_window = (state_reg == SETUP) || (state_reg == PULSE) || (state_reg == HOLD);

  // Cell-facing outputs are registered from the current state, so every strobe
  // and its setup/hold window lag the state by one cycle with identical spacing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      op_reg        <= OP_RESET;
      tx_reg        <= '0;
      rx_reg        <= '0;
      rsp_data_reg  <= '0;
      cmd_ready_reg <= 1'b0;
      busy_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      shift_dr_reg  <= 1'b0;
      sh_t_reg      <= 1'b0;
      com_t_reg     <= 1'b0;
      tlr_reg       <= 1'b0;
      chain_si_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cmd_ready_reg <= (state_next == IDLE);
      busy_reg      <= (state_next != IDLE);

      if (accept) begin
        op_reg <= op_e'(host.cmd_op);
        tx_reg <= host.cmd_data;
      end else if (state_reg == HOLD) begin
        tx_reg <= {tx_reg[CHAIN_LEN-2:0], 1'b0};
      end

      if ((state_reg == SETUP) && (op_reg == OP_SHIFT)) begin
        rx_reg       <= {rx_reg[CHAIN_LEN-2:0], chain_so};
        chain_si_reg <= tx_reg[CHAIN_LEN-1];
      end else if (state_reg == DONE) begin
        chain_si_reg <= 1'b0;
      end

      shift_dr_reg  <= in_bit_window && (op_reg == OP_SHIFT);
      sh_t_reg      <= (state_reg == PULSE) && ((op_reg == OP_SHIFT) || (op_reg == OP_CAPTURE));
      com_t_reg     <= (state_reg == PULSE) && (op_reg == OP_UPDATE);
      tlr_reg       <= (state_reg == RST);
      rsp_valid_reg <= (state_reg == DONE);

      if ((state_reg == DONE) && (op_reg == OP_SHIFT)) begin
        rsp_data_reg <= rx_reg;
      end
    end
  end

  assign host.cmd_ready = cmd_ready_reg;
  assign host.busy      = busy_reg;
  assign host.rsp_valid = rsp_valid_reg;
  assign host.rsp_data  = rsp_data_reg;

  assign Shift_DR       = shift_dr_reg;
  assign BIST_Sh_t_clk  = sh_t_reg;
  assign BIST_Com_t_clk = com_t_reg;
  assign Test_Log_Res   = tlr_reg;
  assign chain_si       = chain_si_reg;

endmodule

// File: tb/tb_bist_chain_ctrl.sv
// Directed bench for bist_chain_ctrl with a behavioural model of the 8-cell chain.
module tb_bist_chain_ctrl;
  import bist_ctrl_pkg::*;

  localparam int N = 8;

  localparam int M_SH_RISE  = 0;
  localparam int M_SH_HIGH  = 1;
  localparam int M_SH_LOAD  = 2;
  localparam int M_COM      = 3;
  localparam int M_TLR_HIGH = 4;
  localparam int M_TLR_RISE = 5;
  localparam int M_SDR_HIGH = 6;
  localparam int M_SDR_RISE = 7;
  localparam int M_RSP      = 8;
  localparam int M_VIOL     = 9;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bist_chain_ctrl_if #(.CHAIN_LEN(N)) host ();

  logic Shift_DR, sh_t, com_t, tlr, chain_si, chain_so;

  bist_chain_ctrl #(
    .CHAIN_LEN  (N),
    .RST_CYCLES (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .host           (host),
    .Shift_DR       (Shift_DR),
    .BIST_Sh_t_clk  (sh_t),
    .BIST_Com_t_clk (com_t),
    .Test_Log_Res   (tlr),
    .chain_si       (chain_si),
    .chain_so       (chain_so)
  );

  // Chain model: shift/capture flops on Sh_t, update flops on Com_t, async clear.
  logic [N-1:0] cells, par_in, par_out, preload_val;
  logic         preload_stb;

  always @(posedge sh_t or posedge preload_stb) begin
    if (preload_stb)   cells <= preload_val;
    else if (Shift_DR) cells <= {cells[N-2:0], chain_si};
    else               cells <= par_in;
  end

  always @(posedge com_t or posedge tlr) begin
    if (tlr) par_out <= '0;
    else     par_out <= cells;
  end

  assign chain_so = cells[N-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int acc_cnt = 0;
  int acc_cyc[$];
  always @(posedge clk) begin
    if (host.cmd_valid && host.cmd_ready) begin
      acc_cnt <= acc_cnt + 1;
      acc_cyc.push_back(cyc);
    end
  end

  int   mon[10] = '{default: 0};
  int   base[10];
  logic prev_sh = 1'b0, prev_tlr = 1'b0, prev_sdr = 1'b0, prev_si = 1'b0;

  always @(negedge clk) begin
    prev_sh  <= sh_t;
    prev_tlr <= tlr;
    prev_sdr <= Shift_DR;
    prev_si  <= chain_si;
    if (sh_t && !prev_sh)       mon[M_SH_RISE]  <= mon[M_SH_RISE] + 1;
    if (sh_t)                   mon[M_SH_HIGH]  <= mon[M_SH_HIGH] + 1;
    if (sh_t && !Shift_DR)      mon[M_SH_LOAD]  <= mon[M_SH_LOAD] + 1;
    if (com_t)                  mon[M_COM]      <= mon[M_COM] + 1;
    if (tlr)                    mon[M_TLR_HIGH] <= mon[M_TLR_HIGH] + 1;
    if (tlr && !prev_tlr)       mon[M_TLR_RISE] <= mon[M_TLR_RISE] + 1;
    if (Shift_DR)               mon[M_SDR_HIGH] <= mon[M_SDR_HIGH] + 1;
    if (Shift_DR && !prev_sdr)  mon[M_SDR_RISE] <= mon[M_SDR_RISE] + 1;
    if (host.rsp_valid)         mon[M_RSP]      <= mon[M_RSP] + 1;
    if ((sh_t || prev_sh) && ((Shift_DR !== prev_sdr) || (chain_si !== prev_si)))
      mon[M_VIOL] <= mon[M_VIOL] + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int d(input int i);
    return mon[i] - base[i];
  endfunction

  task automatic send(input logic [1:0] op, input logic [N-1:0] data, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    base = mon;
    host.cmd_valid = 1'b1;
    host.cmd_op    = op;
    host.cmd_data  = data;
    while (!host.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {31'd0, host.cmd_ready}, 32'd1);
    @(negedge clk);
    acc = cyc;
    host.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int acc, output int lat, output logic [N-1:0] data);
    int n;
    n = 0;
    while (host.rsp_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    lat  = cyc - acc;
    data = host.rsp_data;
    @(negedge clk);
  endtask

  initial begin
    int           acc, lat, k, n0;
    logic [N-1:0] rd;

    host.cmd_valid = 1'b0;
    host.cmd_op    = 2'b00;
    host.cmd_data  = '0;
    preload_stb    = 1'b0;
    preload_val    = '0;
    par_in         = '0;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, host.cmd_ready}, 32'd0);
    check("rst_busy",      {31'd0, host.busy}, 32'd0);
    check("rst_rsp_valid", {31'd0, host.rsp_valid}, 32'd0);
    check("rst_rsp_data",  {24'd0, host.rsp_data}, 32'h00);
    check("rst_strobes",   {28'd0, sh_t, com_t, tlr, Shift_DR}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, host.cmd_ready}, 32'd1);

    // SHIFT A5 into a chain preloaded with 3C
    preload_val = 8'h3C;
    preload_stb = 1'b1;
    #1 preload_stb = 1'b0;
    send(OP_SHIFT, 8'hA5, acc);
    wait_rsp(acc, lat, rd);
    check("shift1_latency", lat, 32'd25);
    check("shift1_rsp",     {24'd0, rd}, 32'h3C);
    check("shift1_cells",   {24'd0, cells}, 32'hA5);
    check("shift1_sh_rise", d(M_SH_RISE), 32'd8);
    check("shift1_sh_high", d(M_SH_HIGH), 32'd8);
    check("shift1_sdr_high", d(M_SDR_HIGH), 32'd24);
    check("shift1_sdr_rise", d(M_SDR_RISE), 32'd1);
    check("shift1_stable",  d(M_VIOL), 32'd0);
    check("shift1_rsp_cnt", d(M_RSP), 32'd1);

    // CAPTURE 5A, then read it back with SHIFT 00
    par_in = 8'h5A;
    send(OP_CAPTURE, 8'h00, acc);
    wait_rsp(acc, lat, rd);
    check("cap_latency",  lat, 32'd4);
    check("cap_sh_rise",  d(M_SH_RISE), 32'd1);
    check("cap_sh_load",  d(M_SH_LOAD), 32'd1);
    check("cap_sdr_high", d(M_SDR_HIGH), 32'd0);
    check("cap_cells",    {24'd0, cells}, 32'h5A);
    check("cap_rsp_held", {24'd0, rd}, 32'h3C);
    send(OP_SHIFT, 8'h00, acc);
    wait_rsp(acc, lat, rd);
    check("shift2_rsp",   {24'd0, rd}, 32'h5A);
    check("shift2_cells", {24'd0, cells}, 32'h00);

    // SHIFT FF, then UPDATE
    send(OP_SHIFT, 8'hFF, acc);
    wait_rsp(acc, lat, rd);
    check("shift3_rsp", {24'd0, rd}, 32'h00);
    send(OP_UPDATE, 8'h00, acc);
    wait_rsp(acc, lat, rd);
    check("upd_latency", lat, 32'd4);
    check("upd_com",     d(M_COM), 32'd1);
    check("upd_sh_high", d(M_SH_HIGH), 32'd0);
    check("upd_par_out", {24'd0, par_out}, 32'hFF);
    check("upd_rsp_held", {24'd0, rd}, 32'h00);

    // RESET command clears the update register
    send(OP_RESET, 8'h00, acc);
    wait_rsp(acc, lat, rd);
    check("rstcmd_latency",  lat, 32'd3);
    check("rstcmd_tlr_high", d(M_TLR_HIGH), 32'd2);
    check("rstcmd_tlr_rise", d(M_TLR_RISE), 32'd1);
    check("rstcmd_par_out",  {24'd0, par_out}, 32'h00);

    // Abort a SHIFT of 3C during its fourth bit; cells were FF
    send(OP_SHIFT, 8'h3C, acc);
    k = 0;
    for (int i = 0; i < 100 && k < 4; i++) begin
      @(negedge clk);
      if (sh_t) k++;
    end
    check("abort_reached_bit4", k, 32'd4);
    reset = 1'b1;
    @(negedge clk);
    check("abort_strobes", {28'd0, sh_t, com_t, tlr, Shift_DR}, 32'd0);
    check("abort_rsp_data", {24'd0, host.rsp_data}, 32'h00);
    check("abort_busy",     {31'd0, host.busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'd0, host.cmd_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check("abort_no_rsp", d(M_RSP), 32'd0);
    check("abort_cells",  {24'd0, cells}, 32'hF3);
    send(OP_SHIFT, 8'h96, acc);
    wait_rsp(acc, lat, rd);
    check("post_abort_latency", lat, 32'd25);
    check("post_abort_rsp",     {24'd0, rd}, 32'hF3);
    check("post_abort_cells",   {24'd0, cells}, 32'h96);

    // cmd_valid held high across three UPDATE commands
    @(negedge clk);
    base = mon;
    n0 = acc_cnt;
    host.cmd_valid = 1'b1;
    host.cmd_op    = OP_UPDATE;
    for (int i = 0; i < 100 && (acc_cnt - n0) < 3; i++) @(negedge clk);
    host.cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("b2b_accepts", acc_cnt - n0, 32'd3);
    check("b2b_rsp_cnt", d(M_RSP), 32'd3);
    check("b2b_com_cnt", d(M_COM), 32'd3);
    if (acc_cyc.size() >= n0 + 3) begin
      check("b2b_gap1", acc_cyc[n0+1] - acc_cyc[n0], 32'd5);
      check("b2b_gap2", acc_cyc[n0+2] - acc_cyc[n0+1], 32'd5);
    end else begin
      check("b2b_accept_log", acc_cyc.size(), n0 + 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bist_chain_ctrl.md
Name: bist_chain_ctrl

Overview:
- Sequencer for one chain of CHAIN_LEN BIST register cells.
- Each cell has a capture/shift flip-flop on BIST_Sh_t_clk, an update flip-flop on BIST_Com_t_clk, a Shift_DR load/shift mux and the Test_Log_Res clear.
- Accepts one host command at a time: reset, capture, shift, update.
- Generates the cell strobes with fixed setup/hold spacing and returns serially unloaded chain contents.

Parameters:
- CHAIN_LEN, 8, number of cells in the chain (>=2).
- RST_CYCLES, 2, cycles Test_Log_Res is held high for the reset command (>=1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  00 RESET, 01 CAPTURE, 10 SHIFT, 11 UPDATE.
- cmd_data  in  CHAIN_LEN  SHIFT payload; bit k ends in cell k.
- rsp_valid  out  1  one-cycle completion pulse for every command.
- rsp_data  out  CHAIN_LEN  SHIFT result; bit k = cell k content before the shift.
- busy  out  1  high whenever state != IDLE.
- Shift_DR  out  1  cell mux select; 1 = shift, 0 = parallel load.
- BIST_Sh_t_clk  out  1  capture/shift strobe to all cells.
- BIST_Com_t_clk  out  1  update strobe to all cells.
- Test_Log_Res  out  1  update-register clear to all cells.
- chain_si  out  1  drives Shift_in of cell 0.
- chain_so  in  1  Shift_out of cell CHAIN_LEN-1.

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1 from the cycle after reset deasserts. rsp_data=0, state IDLE.
- Reset mid-command: abort at the next edge. Strobes and Test_Log_Res drop to 0, no rsp_valid, partially shifted rsp_data is discarded (cleared to 0).
- All strobe outputs are registered (glitch-free).
- Each strobe pulse is exactly one cycle high.
- Shift_DR and chain_si are stable one cycle before and one cycle after every BIST_Sh_t_clk pulse.
- States and sequences:
  - IDLE: wait for accept; latch cmd_op and cmd_data into a tx shift register. cmd_valid while not ready is ignored, not queued.
  - RESET: Test_Log_Res=1 for RST_CYCLES cycles, then DONE.
  - CAPTURE: SETUP(Shift_DR=0) -> PULSE(Sh_t=1) -> HOLD -> DONE.
  - SHIFT: per bit, SETUP -> PULSE -> HOLD, repeated CHAIN_LEN times, then DONE.
    - SETUP: Shift_DR=1, chain_si = tx[CHAIN_LEN-1] (MSB first); chain_so sampled at the end of SETUP into rx, MSB first.
    - HOLD: tx shifts left.
    - The bit counter counts 0..CHAIN_LEN-1. Last HOLD goes to DONE, otherwise back to SETUP.
    - Shift_DR returns to 0 in DONE.
  - UPDATE: SETUP(Shift_DR=0) -> PULSE(Com_t=1) -> HOLD -> DONE.
  - DONE: rsp_valid=1 for one cycle; rsp_data <= rx for SHIFT only, held otherwise. cmd_ready=0. IDLE next cycle.
- Latency from accept edge to rsp_valid:
  - RESET: RST_CYCLES+1.
  - CAPTURE and UPDATE: 4.
  - SHIFT: 3*CHAIN_LEN+1.
- Back-to-back commands: minimum one IDLE cycle between DONE and the next accept.
- Illegal states decode to IDLE.

Decomposition:
- Package bist_ctrl_pkg holds:
  - cmd_op encodings OP_RESET/OP_CAPTURE/OP_SHIFT/OP_UPDATE.
  - state enum IDLE/RST/SETUP/PULSE/HOLD/DONE.
  - the function for the counter width, clog2(CHAIN_LEN).
- One sub-module, bist_bit_counter: load, decrement and terminal-count flag, shared by the bit loop and the reset hold.

Test Plan:
- Reset, then SHIFT with cmd_data=8'hA5; a cell model is preloaded 8'h3C. Required:
  - rsp_data=8'h3C.
  - cells=8'hA5.
  - exactly 8 Sh_t pulses.
  - rsp_valid 25 cycles after accept.
  - Shift_DR high from the first SETUP through the last HOLD.
- CAPTURE with cell Par_in=8'h5A, then SHIFT 8'h00. Required:
  - 1 Sh_t pulse with Shift_DR=0 throughout.
  - rsp_data=8'h5A.
- SHIFT 8'hFF then UPDATE. Required:
  - one Com_t pulse, zero Sh_t pulses during UPDATE.
  - Par_out=8'hFF.
  - rsp_valid 4 cycles after accept.
- RESET with RST_CYCLES=2 after Par_out=8'hFF. Required:
  - Test_Log_Res high exactly 2 cycles.
  - Par_out=8'h00.
  - rsp_valid 3 cycles after accept.
- Assert reset during bit 4 of a SHIFT. Required:
  - strobes 0 next cycle, no rsp_valid, rsp_data=0.
  - cmd_ready=1 after reset release.
  - a following SHIFT completes normally.
- Hold cmd_valid high continuously across 3 commands. Required:
  - each is accepted only in IDLE.
  - cmd_valid while busy is ignored.
  - one rsp_valid per accepted command.
